key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Input conditioner for the four board push-buttons KEY3..KEY0, which are active-low and bouncy.
- Synchronises, debounces and edge-detects each key.
- Drives the clean active-high levels consumed by the timer/clock mode blocks (key_next/inc/dec/start).
- Also drives single-cycle press pulses, with optional auto-repeat, for consumers running on the fast system clock.

Parameters:
- NUM_KEYS, 4, number of key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a press or release (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000, held cycles after acceptance before the first repeat pulse.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses.
- REPEAT_MASK, 4'b0110, per-key auto-repeat enable (inc/dec only by default).
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_n  in  NUM_KEYS  raw asynchronous button pins, 0 = pressed.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse on accepted press and on each repeat.
- key_release  out  NUM_KEYS  one-cycle pulse on accepted release.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - all outputs 0;
  - both synchroniser stages 1 (released);
  - every channel state ARM, counters 0.
- Synchroniser: two flops per key. s = ~key_n after two stages, so 1 = pressed. All decisions use s only.
- Per-channel FSM, with one counter cnt:
  - ARM: needs s==0 for DEBOUNCE_CYCLES consecutive cycles, then goes to IDLE. An s==1 sample clears cnt. A key held through reset never produces key_press or key_level until it has been released and pressed again.
  - IDLE: on s==1, go to DEB_PRESS with cnt=1.
  - DEB_PRESS: s==1 increments cnt; s==0 returns to IDLE with cnt=0. When cnt==DEBOUNCE_CYCLES, go to HELD: key_level<=1, key_press pulses one cycle, cnt<=0.
  - HELD: s==0 goes to DEB_REL with cnt=1. Otherwise, if REPEAT_MASK[i], increment cnt; at cnt==REPEAT_DELAY, pulse key_press and go to REPEAT with cnt=0.
  - REPEAT: s==0 goes to DEB_REL with cnt=1. Otherwise increment cnt; at cnt==REPEAT_PERIOD, pulse key_press and set cnt=0.
  - DEB_REL: key_level stays 1 and no repeat pulses are issued. s==0 increments cnt; s==1 returns to HELD with cnt=0 (repeat timing restarts). At cnt==DEBOUNCE_CYCLES: key_level<=0, key_release pulses, go to IDLE.
- Latency: a clean press edge on key_n gives key_level/key_press exactly DEBOUNCE_CYCLES+2 clocks later. Release latency is identical.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Channels are fully independent. Simultaneous presses on several keys pulse in the same cycle; there is no priority or masking.
- key_press and key_release are never asserted in the same cycle for the same key.
- Reset mid-operation: outputs drop to 0 the next cycle and the channel returns to ARM. No release pulse is generated.
- Counters saturate logically by the state transitions and never wrap.

Decomposition:
- Package key_pkg holds:
  - the state enum (ARM, IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL);
  - the default count constants;
  - key index constants KEY_START=0, KEY_DEC=1, KEY_INC=2, KEY_NEXT=3.
- Sub-module key_channel: one synchroniser + FSM + counter with a scalar repeat_en input. The top generates NUM_KEYS instances and slices REPEAT_MASK.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset with all keys released, then wait 6 cycles; press key0 cleanly at cycle 20 -> key_level[0] rises and key_press[0] pulses at cycle 26; release at cycle 40 -> key_release[0] pulses and key_level[0] falls at cycle 46.
- Key1 bounces pressed 2 cycles / released 1 cycle, three times, then stays pressed -> exactly one key_press[1], 6 cycles after the final stable edge; no earlier output.
- Hold key2 (REPEAT_MASK bit set) for 30 cycles after acceptance -> key_press[2] pulses at acceptance, then at +11, +15, +19, +23, +27; key_level[2] stays 1 throughout. Key0 held equally long -> single pulse only.
- Hold key3 through reset deassertion -> no key_level[3] or key_press[3]; release for 4+ cycles, then press -> normal acceptance.
- Press key0 and key3 in the same cycle -> both key_press bits pulse in the same cycle; assert rst during HELD -> all outputs 0 the next cycle, no key_release pulse.
- During DEB_REL, re-press key2 after a 2-cycle release -> no key_release; key_level stays 1; repeat restarts with the next pulse REPEAT_DELAY+1 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the push-button conditioner.
//   key_state_e   per-channel debounce / repeat state
//   Def*          default timing (50 MHz system clock)
//   KEY_*         bit index of each board key in the key_* buses
package key_pkg;

  // Per-channel FSM states. StArm only exists after reset: a key must be seen
  // released for a full debounce window before any press can be accepted.
  typedef enum logic [2:0] {
    StArm,
    StIdle,
    StDebPress,
    StHeld,
    StRepeat,
    StDebRel
  } key_state_e;

  localparam int unsigned DefNumKeys        = 4;
  localparam int unsigned DefDebounceCycles = 1000000;   // 20 ms at 50 MHz
  localparam int unsigned DefRepeatDelay    = 25000000;  // 500 ms
  localparam int unsigned DefRepeatPeriod   = 10000000;  // 200 ms
  localparam int unsigned DefCntW           = 25;
  localparam logic [3:0]  DefRepeatMask     = 4'b0110;   // inc/dec only

  // Key positions on the key_* buses.
  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_DEC   = 1;
  localparam int unsigned KEY_INC   = 2;
  localparam int unsigned KEY_NEXT  = 3;

endpackage

// File: rtl/key_channel.sv
// key_channel: one push-button channel.
//   Two-flop synchroniser on the raw active-low pin, then a debounce / auto-repeat
//   FSM sharing a single counter. All outputs are registered.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_n        raw asynchronous pin, 0 = pressed
//   repeat_en    enables auto-repeat press pulses while held
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse on accepted press and on each repeat
//   key_release  one-cycle pulse on accepted release
//
// Timing notes:
//   - Debounce counts stable samples of s, including the sample that leaves
//     StIdle/StHeld, so a clean edge on key_n appears on the outputs
//     DEBOUNCE_CYCLES + 2 clocks later (two of those are the synchroniser).
//   - Repeat compares the current count, so the first repeat pulse comes
//     REPEAT_DELAY + 1 clocks after acceptance and then every REPEAT_PERIOD + 1.
//   - DEBOUNCE_CYCLES must be at least 3 so the synchroniser's reset value
//     cannot arm a key that is held through reset.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic repeat_en,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepDelay  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RepPeriod = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  // Synchroniser stages hold the raw (active-low) pin value; reset = released.
  logic sync1_q, sync2_q;
  logic s;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      StArm: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StIdle: begin
        if (s) begin
          state_d = StDebPress;
          cnt_d   = CntOne;
        end
      end

      StDebPress: begin
        if (!s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StHeld: begin
        if (!s) begin
          state_d = StDebRel;
          cnt_d   = CntOne;
        end else if (repeat_en) begin
          if (cnt_q == RepDelay) begin
            state_d = StRepeat;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      StRepeat: begin
        if (!s) begin
          state_d = StDebRel;
          cnt_d   = CntOne;
        end else if (cnt_q == RepPeriod) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StDebRel: begin
        // Level stays high while the release is being qualified; a bounce back
        // to pressed restarts the repeat timing from scratch.
        if (s) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StArm;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StArm;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and edge-detect the board push-buttons.
//   One independent key_channel per key; channels never mask each other, so
//   simultaneous presses pulse in the same cycle.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_n        raw asynchronous button pins, 0 = pressed
//   key_level    debounced levels, 1 = pressed (for the timer/clock mode blocks)
//   key_press    one-cycle pulse on accepted press and on each auto-repeat
//   key_release  one-cycle pulse on accepted release
//
// Bit positions follow key_pkg::KEY_* (start, dec, inc, next).
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned          NUM_KEYS        = DefNumKeys,
  parameter int unsigned          DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned          REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned          REPEAT_PERIOD   = DefRepeatPeriod,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = NUM_KEYS'(DefRepeatMask),
  parameter int unsigned          CNT_W           = DefCntW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n[i]),
      .repeat_en   (REPEAT_MASK[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing
// (debounce 4, repeat delay 10, repeat period 3).
module tb_key_conditioner;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int total = 0;
  int bad   = 0;

  key_conditioner #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (4'b0110),
    .CNT_W           (25)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_n = 4'hF;
    repeat (3) tick();
    total++;
    if ({key_level, key_press, key_release} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 000", {key_level, key_press, key_release});
    end
    rst = 1'b0;
    repeat (6) tick();
    total++;
    if ({key_level, key_press, key_release} !== 12'h000) begin
      bad++;
      $display("FAIL post_reset_idle: got %h want 000", {key_level, key_press, key_release});
    end
  endtask

  task automatic test_clean_press();
    key_n[KEY_START] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (i < 6 && {key_level[0], key_press[0]} !== 2'b00) begin
        bad++;
        $display("FAIL press_early c%0d: got %b want 00", i, {key_level[0], key_press[0]});
      end else if (i == 6 && {key_level, key_press} !== 8'h11) begin
        bad++;
        $display("FAIL press_latency: got %h want 11", {key_level, key_press});
      end
    end
    tick();
    total++;
    if ({key_level[0], key_press[0]} !== 2'b10) begin
      bad++;
      $display("FAIL press_single_pulse: got %b want 10", {key_level[0], key_press[0]});
    end
    repeat (8) tick();
    key_n[KEY_START] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (i < 6 && {key_level[0], key_release[0]} !== 2'b10) begin
        bad++;
        $display("FAIL release_early c%0d: got %b want 10", i, {key_level[0], key_release[0]});
      end else if (i == 6 && {key_level[0], key_press[0], key_release} !== 6'b00_0001) begin
        bad++;
        $display("FAIL release_latency: got %b want 000001",
                 {key_level[0], key_press[0], key_release});
      end
    end
    tick();
    total++;
    if (key_release !== 4'h0) begin
      bad++;
      $display("FAIL release_single_pulse: got %b want 0000", key_release);
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 3; r++) begin
      key_n[KEY_DEC] = 1'b0;
      tick();
      tick();
      key_n[KEY_DEC] = 1'b1;
      tick();
      total++;
      if ({key_level[1], key_press[1]} !== 2'b00) begin
        bad++;
        $display("FAIL bounce_quiet r%0d: got %b want 00", r, {key_level[1], key_press[1]});
      end
    end
    key_n[KEY_DEC] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if (i < 6 && {key_level[1], key_press[1]} !== 2'b00) begin
        bad++;
        $display("FAIL bounce_early c%0d: got %b want 00", i, {key_level[1], key_press[1]});
      end else if (i == 6 && {key_level[1], key_press[1]} !== 2'b11) begin
        bad++;
        $display("FAIL bounce_accept: got %b want 11", {key_level[1], key_press[1]});
      end else if (i > 6 && {key_level[1], key_press[1]} !== 2'b10) begin
        bad++;
        $display("FAIL bounce_extra_pulse c%0d: got %b want 10", i, {key_level[1], key_press[1]});
      end
    end
    key_n[KEY_DEC] = 1'b1;
    repeat (8) tick();
    total++;
    if (key_level[1] !== 1'b0) begin
      bad++;
      $display("FAIL bounce_released: got %b want 0", key_level[1]);
    end
  endtask

  task automatic test_repeat();
    logic [30:0] rec2, rec0, exp2, exp0;
    logic        lvl_ok;
    rec2   = '0;
    rec0   = '0;
    lvl_ok = 1'b1;
    exp2   = '0;
    exp0   = '0;
    exp2[0]  = 1'b1;
    exp2[11] = 1'b1;
    exp2[15] = 1'b1;
    exp2[19] = 1'b1;
    exp2[23] = 1'b1;
    exp2[27] = 1'b1;
    exp0[0]  = 1'b1;
    key_n[KEY_INC]   = 1'b0;
    key_n[KEY_START] = 1'b0;
    repeat (6) tick();
    total++;
    if (key_press !== 4'b0101) begin
      bad++;
      $display("FAIL repeat_accept: got %b want 0101", key_press);
    end
    rec2[0] = key_press[2];
    rec0[0] = key_press[0];
    for (int j = 1; j <= 30; j++) begin
      tick();
      rec2[j] = key_press[2];
      rec0[j] = key_press[0];
      if (key_level[2] !== 1'b1) lvl_ok = 1'b0;
    end
    total++;
    if (rec2 !== exp2) begin
      bad++;
      $display("FAIL repeat_pattern_key2: got %h want %h", rec2, exp2);
    end
    total++;
    if (rec0 !== exp0) begin
      bad++;
      $display("FAIL no_repeat_key0: got %h want %h", rec0, exp0);
    end
    total++;
    if (lvl_ok !== 1'b1) begin
      bad++;
      $display("FAIL repeat_level_held: got %b want 1", lvl_ok);
    end
    key_n[KEY_INC]   = 1'b1;
    key_n[KEY_START] = 1'b1;
    repeat (8) tick();
    total++;
    if (key_level !== 4'h0) begin
      bad++;
      $display("FAIL repeat_released: got %b want 0000", key_level);
    end
  endtask

  task automatic test_held_through_reset();
    rst = 1'b1;
    key_n[KEY_NEXT] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++;
      if ({key_level[3], key_press[3]} !== 2'b00) begin
        bad++;
        $display("FAIL held_reset_quiet c%0d: got %b want 00", i, {key_level[3], key_press[3]});
      end
    end
    key_n[KEY_NEXT] = 1'b1;
    repeat (8) tick();
    key_n[KEY_NEXT] = 1'b0;
    repeat (6) tick();
    total++;
    if ({key_level[3], key_press[3]} !== 2'b11) begin
      bad++;
      $display("FAIL held_reset_repress: got %b want 11", {key_level[3], key_press[3]});
    end
    key_n[KEY_NEXT] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_simultaneous_and_reset();
    key_n[KEY_START] = 1'b0;
    key_n[KEY_NEXT]  = 1'b0;
    repeat (6) tick();
    total++;
    if ({key_level, key_press} !== 8'h99) begin
      bad++;
      $display("FAIL simultaneous_press: got %h want 99", {key_level, key_press});
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({key_level, key_press, key_release} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_held: got %h want 000", {key_level, key_press, key_release});
    end
    key_n = 4'hF;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if ({key_level, key_release} !== 8'h00) begin
        bad++;
        $display("FAIL reset_no_release c%0d: got %h want 00", i, {key_level, key_release});
      end
    end
  endtask

  task automatic test_back_to_back_repress();
    logic [20:0] rec_p, exp_p;
    logic        rel_seen, lvl_ok;
    rec_p    = '0;
    exp_p    = '0;
    exp_p[18] = 1'b1;
    rel_seen = 1'b0;
    lvl_ok   = 1'b1;
    key_n[KEY_INC] = 1'b0;
    repeat (6) tick();
    total++;
    if ({key_level[2], key_press[2]} !== 2'b11) begin
      bad++;
      $display("FAIL repress_accept: got %b want 11", {key_level[2], key_press[2]});
    end
    for (int j = 1; j <= 20; j++) begin
      tick();
      rec_p[j] = key_press[2];
      if (key_release[2] !== 1'b0) rel_seen = 1'b1;
      if (key_level[2] !== 1'b1) lvl_ok = 1'b0;
      if (j == 2) key_n[KEY_INC] = 1'b1;
      if (j == 4) key_n[KEY_INC] = 1'b0;
    end
    total++;
    if (rel_seen !== 1'b0) begin
      bad++;
      $display("FAIL repress_no_release: got %b want 0", rel_seen);
    end
    total++;
    if (lvl_ok !== 1'b1) begin
      bad++;
      $display("FAIL repress_level_held: got %b want 1", lvl_ok);
    end
    total++;
    if (rec_p !== exp_p) begin
      bad++;
      $display("FAIL repress_repeat_restart: got %h want %h", rec_p, exp_p);
    end
    key_n[KEY_INC] = 1'b1;
    repeat (10) tick();
    total++;
    if (key_level !== 4'h0) begin
      bad++;
      $display("FAIL repress_final_release: got %b want 0000", key_level);
    end
  endtask

  initial begin
    rst   = 1'b1;
    key_n = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_held_through_reset();
    test_simultaneous_and_reset();
    test_back_to_back_repress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
